seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 92 +++++++++
 tb/tb_seq_divider.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per cycle, with signed/unsigned modes and divide-by-zero flagging.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo, dsr, rem;
    logic             neg_q, neg_r;
    logic             a_neg, b_neg, fit, last;
    logic [WIDTH-1:0] a_mag, b_mag, quo_nx, rem_nx;
    logic [WIDTH:0]   shifted, diff;

    assign busy_o = state == CALC;
    assign done_o = state == DONE;

    always_comb begin
        a_neg    = signed_i & dividend_i[WIDTH-1];
        b_neg    = signed_i & divisor_i[WIDTH-1];
        a_mag    = a_neg ? -dividend_i : dividend_i;
        b_mag    = b_neg ? -divisor_i : divisor_i;
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dsr};
        fit      = ~diff[WIDTH];
        rem_nx   = fit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nx   = {quo[WIDTH-2:0], fit};
        last     = cnt == CW'(WIDTH - 1);
        state_nx = state;
        if (state == IDLE && start_i)
            state_nx = (divisor_i == '0) ? DONE : CALC;
        else if (state == CALC && last)
            state_nx = DONE;
        else if (state == DONE)
            state_nx = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            quo         <= '0;
            dsr         <= '0;
            rem         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start_i) begin
                if (divisor_i == '0) begin
                    quotient_o  <= '1;
                    remainder_o <= dividend_i;
                    div_zero_o  <= 1'b1;
                end else begin
                    quo   <= a_mag;
                    dsr   <= b_mag;
                    rem   <= '0;
                    cnt   <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                end
            end else if (state == CALC) begin
                quo <= quo_nx;
                rem <= rem_nx;
                cnt <= cnt + 1'b1;
                if (last) begin
                    // Sign fix-up is folded into the final iteration so results land on the DONE entry edge.
                    quotient_o  <= neg_q ? -quo_nx : quo_nx;
                    remainder_o <= neg_r ? -rem_nx : rem_nx;
                    div_zero_o  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed table-driven check of seq_divider plus hand sequences for ignore-start, reset abort and back-to-back.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient, remainder;
    logic        busy, done, div_zero;

    int tests = 0;
    int fails = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn),
        .dividend_i(dividend), .divisor_i(divisor),
        .quotient_o(quotient), .remainder_o(remainder),
        .busy_o(busy), .done_o(done), .div_zero_o(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one operation and observe it until done_o (bounded).
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_n, output bit ovl);
        lat = 0;
        busy_n = 0;
        ovl = 0;
        @(negedge clk);
        sgn = s; dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            busy_n += int'(busy);
            if (busy && done) ovl = 1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    vec_t vt[13];
    int   lat, busy_n, n, dcnt;
    bit   ovl;

    initial begin
        vt[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vt[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vt[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
        vt[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vt[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
        vt[5]  = '{1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1};
        vt[6]  = '{1'b1, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1};
        vt[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vt[8]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0};
        vt[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
        vt[10] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vt[11] = '{1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
        vt[12] = '{1'b0, 32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          1'b0};

        #2 rst = 1'b0;
        #1;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].s, vt[i].a, vt[i].b, lat, busy_n, ovl);
            chk($sformatf("v%0d_latency", i), lat, (vt[i].b == 0) ? 32'd1 : 32'd33);
            chk($sformatf("v%0d_busy_cycles", i), busy_n, (vt[i].b == 0) ? 32'd0 : 32'd32);
            chk($sformatf("v%0d_busy_done_overlap", i), {31'd0, ovl}, 32'd0);
            chk($sformatf("v%0d_quotient", i), quotient, vt[i].q);
            chk($sformatf("v%0d_remainder", i), remainder, vt[i].r);
            chk($sformatf("v%0d_div_zero", i), {31'd0, div_zero}, {31'd0, vt[i].dz});
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // start_i pulsed with new operands during CALC is ignored.
        @(negedge clk);
        sgn = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ign_hold_quotient", quotient, 32'h0DEADBEE);
        sgn = 1'b1; dividend = 32'd50; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 11; k <= 100; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("ign_latency", lat, 32'd33);
        chk("ign_quotient", quotient, 32'd14);
        chk("ign_remainder", remainder, 32'd2);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n += int'(busy) + int'(done);
        end
        chk("ign_no_second_op", n, 32'd0);
        chk("ign_hold_after", remainder, 32'd2);

        // Reset asserted mid-CALC aborts the operation.
        @(negedge clk);
        sgn = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_flags", {29'd0, busy, done, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            dcnt += int'(done) + int'(busy);
        end
        chk("abort_no_done", dcnt, 32'd0);
        run_op(1'b0, 32'd100, 32'd7, lat, busy_n, ovl);
        chk("after_rst_latency", lat, 32'd33);
        chk("after_rst_quotient", quotient, 32'd14);
        chk("after_rst_remainder", remainder, 32'd2);

        // start_i held from DONE into IDLE is accepted on the first IDLE edge.
        @(negedge clk);
        sgn = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("b2b_first_latency", lat, 32'd33);
        dividend = 32'h1234; divisor = 32'd0;
        @(negedge clk);
        chk("b2b_idle_gap", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_done", {30'd0, busy, done}, 32'd1);
        chk("b2b_second_quotient", quotient, 32'hFFFFFFFF);
        chk("b2b_second_remainder", remainder, 32'h1234);
        chk("b2b_second_div_zero", {31'd0, div_zero}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
